// File: rtl/exception_ctrl_multi_if.sv
// Bus bundle between the exception controller and the fetch/execute/decode side.
// master = pipeline side driving events and PCs; slave = exception controller.
interface exception_ctrl_multi_if #(
  parameter int unsigned N    = 64,
  parameter int unsigned NSRC = 4
);
  logic [NSRC-1:0]   exc_req;
  logic [NSRC-1:0]   exc_en;
  logic [4*NSRC-1:0] estatus;
  logic              eret;
  logic [N-1:0]      next_pc;
  logic [N-1:0]      imem_addr;
  logic [N-1:0]      alu_branch;
  logic [1:0]        edata_sel;
  logic [NSRC-1:0]   exc_ack;
  logic              eproc;
  logic [N-1:0]      evaddr;
  logic [N-1:0]      pc_branch;
  logic [N-1:0]      read_data;
  logic              in_handler;

  modport master (
    output exc_req, exc_en, estatus, eret, next_pc, imem_addr, alu_branch, edata_sel,
    input  exc_ack, eproc, evaddr, pc_branch, read_data, in_handler
  );

  modport slave (
    input  exc_req, exc_en, estatus, eret, next_pc, imem_addr, alu_branch, edata_sel,
    output exc_ack, eproc, evaddr, pc_branch, read_data, in_handler
  );
endinterface

// File: rtl/exception_ctrl_multi.sv
// Multi-source exception controller: latches maskable events, takes the highest
// priority one, redirects fetch to its vector and saves ELR/ERR/ESR for ERET/MRS.
module exception_ctrl_multi #(
  parameter int unsigned N          = 64,
  parameter int unsigned NSRC       = 4,
  parameter logic [N-1:0] VEC_BASE   = N'(64'hD8),
  parameter logic [N-1:0] VEC_STRIDE = N'(64'h20)
) (
  input  logic                  clk,
  input  logic                  reset,
  exception_ctrl_multi_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TAKE    = 2'd1,
    ST_HANDLER = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [NSRC-1:0] pending_r;
  logic [NSRC-1:0] elig_s;
  logic [NSRC-1:0] clr_s;
  logic [3:0]      sel_s;
  logic [3:0]      sel_idx_r;
  logic [3:0]      status_s;
  logic [N-1:0]    elr_r;
  logic [N-1:0]    err_r;
  logic [N-1:0]    esr_r;

  // Fixed priority: lowest set index wins.
  function automatic logic [3:0] prio_sel(input logic [NSRC-1:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign elig_s = pending_r & bus.exc_en;
  assign sel_s  = prio_sel(elig_s);

  // Pending-clear mask and status nibble of the source being taken.
  always_comb begin
    clr_s    = '0;
    status_s = 4'd0;
    if (state_r == ST_TAKE) begin
      clr_s = NSRC'(1'b1) << sel_idx_r;
    end else begin
      clr_s = '0;
    end
    for (int i = 0; i < NSRC; i++) begin
      if (sel_idx_r == 4'(i)) begin
        status_s = bus.estatus[4*i +: 4];
      end else begin
        status_s = status_s;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (elig_s != '0) begin
          state_nxt_s = ST_TAKE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_TAKE: state_nxt_s = ST_HANDLER;
      ST_HANDLER: begin
        if (bus.eret) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HANDLER;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, pending set and saved-register updates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      pending_r <= '0;
      sel_idx_r <= 4'd0;
      elr_r     <= '0;
      err_r     <= '0;
      esr_r     <= '0;
    end else begin
      state_r   <= state_nxt_s;
      // A fresh request on a bit being cleared keeps it pending.
      pending_r <= (pending_r & ~clr_s) | bus.exc_req;
      if (state_r == ST_IDLE && elig_s != '0) begin
        sel_idx_r <= sel_s;
      end else begin
        sel_idx_r <= sel_idx_r;
      end
      if (state_r == ST_TAKE) begin
        elr_r <= bus.imem_addr;
        err_r <= bus.next_pc;
        esr_r <= N'({sel_idx_r, status_s});
      end else begin
        elr_r <= elr_r;
        err_r <= err_r;
        esr_r <= esr_r;
      end
    end
  end

  // Fetch redirect, acknowledge and saved-register read port.
  always_comb begin
    bus.eproc      = 1'b0;
    bus.exc_ack    = '0;
    bus.evaddr     = VEC_BASE;
    bus.in_handler = 1'b0;
    bus.pc_branch  = bus.alu_branch;
    bus.read_data  = '0;
    if (state_r == ST_TAKE) begin
      bus.eproc   = 1'b1;
      bus.exc_ack = NSRC'(1'b1) << sel_idx_r;
      bus.evaddr  = VEC_BASE + VEC_STRIDE * N'(sel_idx_r);
    end else begin
      bus.eproc   = 1'b0;
    end
    if (state_r == ST_HANDLER) begin
      bus.in_handler = 1'b1;
      if (bus.eret) begin
        bus.pc_branch = err_r;
      end else begin
        bus.pc_branch = bus.alu_branch;
      end
    end else begin
      bus.in_handler = 1'b0;
    end
    case (bus.edata_sel)
      2'b00:   bus.read_data = err_r;
      2'b01:   bus.read_data = elr_r;
      2'b10:   bus.read_data = esr_r;
      2'b11:   bus.read_data = '0;
      default: bus.read_data = '0;
    endcase
  end

endmodule

// File: tb/tb_exception_ctrl_multi.sv
// Directed bench for exception_ctrl_multi with hand-computed expectations.
module tb_exception_ctrl_multi;
  logic clk;
  logic reset;
  int   checks_cnt;
  int   errors_cnt;

  exception_ctrl_multi_if #(.N(64), .NSRC(4)) bus ();

  exception_ctrl_multi #(.N(64), .NSRC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_saved(input string tag, input logic [63:0] err_e,
                             input logic [63:0] elr_e, input logic [63:0] esr_e);
    bus.edata_sel = 2'b00; #1; check_val({tag, "_err"}, bus.read_data, err_e);
    bus.edata_sel = 2'b01; #1; check_val({tag, "_elr"}, bus.read_data, elr_e);
    bus.edata_sel = 2'b10; #1; check_val({tag, "_esr"}, bus.read_data, esr_e);
    bus.edata_sel = 2'b11; #1; check_val({tag, "_zero"}, bus.read_data, 64'h0);
    bus.edata_sel = 2'b00;
  endtask

  initial begin
    checks_cnt     = 0;
    errors_cnt     = 0;
    reset          = 1'b0;
    bus.exc_req    = 4'hF;
    bus.exc_en     = 4'hF;
    bus.estatus    = 16'hA357;
    bus.eret       = 1'b0;
    bus.next_pc    = 64'h0;
    bus.imem_addr  = 64'h0;
    bus.alu_branch = 64'h777;
    bus.edata_sel  = 2'b00;

    // Reset held two edges while every source requests.
    tick(); tick();
    check_val("rst_eproc", {63'h0, bus.eproc}, 64'h0);
    check_val("rst_ack", {60'h0, bus.exc_ack}, 64'h0);
    check_val("rst_evaddr", bus.evaddr, 64'hD8);
    check_val("rst_inh", {63'h0, bus.in_handler}, 64'h0);
    check_val("rst_pcb", bus.pc_branch, 64'h777);
    check_saved("rst", 64'h0, 64'h0, 64'h0);
    reset       = 1'b1;
    bus.exc_req = 4'h0;
    for (int i = 0; i < 4; i++) begin
      #1; check_val("idle_after_rst", {63'h0, bus.eproc}, 64'h0);
      tick();
    end

    // Single request on source 2.
    bus.imem_addr = 64'h100;
    bus.next_pc   = 64'h104;
    bus.exc_req   = 4'b0100;
    tick();
    bus.exc_req = 4'b0000;
    #1; check_val("s2_c1_eproc", {63'h0, bus.eproc}, 64'h0);
    tick();
    check_val("s2_eproc", {63'h0, bus.eproc}, 64'h1);
    check_val("s2_evaddr", bus.evaddr, 64'h118);
    check_val("s2_ack", {60'h0, bus.exc_ack}, 64'h4);
    tick();
    check_val("s2_inh", {63'h0, bus.in_handler}, 64'h1);
    check_val("s2_eproc_off", {63'h0, bus.eproc}, 64'h0);
    check_saved("s2", 64'h104, 64'h100, 64'h23);
    bus.eret = 1'b1;
    #1; check_val("s2_eret_pcb", bus.pc_branch, 64'h104);
    tick();
    bus.eret = 1'b0;
    #1; check_val("s2_back_idle", {63'h0, bus.in_handler}, 64'h0);

    // Sources 1 and 3 together: 1 first, 3 after ERET.
    bus.exc_req = 4'b1010;
    tick();
    bus.exc_req = 4'b0000;
    tick();
    bus.imem_addr = 64'h200;
    bus.next_pc   = 64'h204;
    #1;
    check_val("s1_evaddr", bus.evaddr, 64'hF8);
    check_val("s1_ack", {60'h0, bus.exc_ack}, 64'h2);
    tick();
    check_saved("s1", 64'h204, 64'h200, 64'h15);
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    #1; check_val("s3_idle_gap", {63'h0, bus.eproc}, 64'h0);
    tick();
    bus.imem_addr = 64'h100;
    bus.next_pc   = 64'h104;
    #1;
    check_val("s3_evaddr", bus.evaddr, 64'h138);
    check_val("s3_ack", {60'h0, bus.exc_ack}, 64'h8);
    tick();
    check_saved("s3", 64'h104, 64'h100, 64'h3A);

    // Source 0 requested during HANDLER is held until return.
    bus.exc_req = 4'b0001;
    tick();
    bus.exc_req = 4'b0000;
    #1;
    check_val("held_ack", {60'h0, bus.exc_ack}, 64'h0);
    check_val("held_eproc", {63'h0, bus.eproc}, 64'h0);
    bus.alu_branch = 64'h500;
    bus.eret       = 1'b1;
    #1;
    check_val("held_pcb", bus.pc_branch, 64'h104);
    check_val("held_ack_eret", {60'h0, bus.exc_ack}, 64'h0);
    tick();
    bus.eret = 1'b0;
    #1;
    check_val("held_idle_eproc", {63'h0, bus.eproc}, 64'h0);
    check_val("held_idle_pcb", bus.pc_branch, 64'h500);
    tick();
    check_val("s0_evaddr", bus.evaddr, 64'hD8);
    check_val("s0_ack", {60'h0, bus.exc_ack}, 64'h1);
    tick();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;

    // Masked source 0 stays pending; ERET in IDLE is ignored.
    bus.exc_en  = 4'b1110;
    bus.exc_req = 4'b0001;
    tick();
    bus.exc_req = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      #1; check_val("masked_eproc", {63'h0, bus.eproc}, 64'h0);
      tick();
    end
    bus.eret = 1'b1;
    #1;
    check_val("idle_eret_pcb", bus.pc_branch, 64'h500);
    check_val("idle_eret_inh", {63'h0, bus.in_handler}, 64'h0);
    tick();
    bus.eret = 1'b0;
    #1; check_val("idle_eret_state", {63'h0, bus.eproc}, 64'h0);
    bus.exc_en = 4'hF;
    #1; check_val("unmask_same_cyc", {63'h0, bus.eproc}, 64'h0);
    tick();
    bus.imem_addr = 64'h300;
    bus.next_pc   = 64'h304;
    #1;
    check_val("unmask_eproc", {63'h0, bus.eproc}, 64'h1);
    check_val("unmask_evaddr", bus.evaddr, 64'hD8);
    tick();
    check_saved("s0b", 64'h304, 64'h300, 64'h07);

    // Reset in HANDLER with a simultaneous request.
    check_val("pre_rst_inh", {63'h0, bus.in_handler}, 64'h1);
    reset       = 1'b0;
    bus.exc_req = 4'b0100;
    tick();
    reset       = 1'b1;
    bus.exc_req = 4'b0000;
    #1;
    check_val("mid_rst_inh", {63'h0, bus.in_handler}, 64'h0);
    check_saved("mid_rst", 64'h0, 64'h0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      #1; check_val("mid_rst_pend", {63'h0, bus.eproc}, 64'h0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end
endmodule

// File: doc/exception_ctrl_multi.md
Name: exception_ctrl_multi

Overview:
- Parametrised, multi-source successor to the single-source exception unit of the single-cycle LEGv8 datapath.
- Latches up to NSRC maskable exception events and picks the highest-priority one. It redirects fetch to a per-source vector and saves ELR/ERR/ESR.
- Sits between fetch, execute and decode. It supplies the branch-target mux for ERET and the MRS-style read port for the saved registers.

Parameters:
- N, 64, datapath/PC width.
- NSRC, 4, number of exception sources (1..16); index 0 is highest priority.
- VEC_BASE, 64'hD8, vector address of source 0.
- VEC_STRIDE, 64'h20, byte distance between consecutive source vectors.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- exc_req  in  NSRC  one-cycle event pulses, one per source.
- exc_en  in  NSRC  per-source enable mask; 1 = may be taken.
- estatus  in  4*NSRC  per-source 4-bit status code; source i at [4i+3:4i].
- eret  in  1  ERET instruction in execution.
- next_pc  in  N  PC+4 of the current instruction.
- imem_addr  in  N  PC of the current instruction.
- alu_branch  in  N  normal branch target from execute.
- edata_sel  in  2  saved-register read select.
- exc_ack  out  NSRC  one-hot acknowledge of the taken source.
- eproc  out  1  fetch must load evaddr this cycle.
- evaddr  out  N  exception vector address.
- pc_branch  out  N  branch target to fetch.
- read_data  out  N  selected saved register.
- in_handler  out  1  handler running; further exceptions are held.

Behaviour:
- State machine: IDLE, TAKE, HANDLER.
- Reset (reset==0 at an edge): state=IDLE; pending, ELR, ERR, ESR and sel_idx = 0. Reset overrides everything, including mid-TAKE and mid-HANDLER.
- Pending register:
  - Every edge: pending <= (pending & ~clr) | exc_req, where clr = one-hot of sel_idx during TAKE, else 0.
  - A new request on the same bit in the same cycle as its clear wins (stays pending).
  - Masked sources stay pending and become eligible when enabled.
- Eligible set = pending & exc_en. sel = lowest set index (fixed priority).
- IDLE:
  - If eligible != 0, go to TAKE and register sel_idx = sel.
  - eret is ignored.
- TAKE (exactly one cycle):
  - eproc=1; evaddr = VEC_BASE + sel_idx*VEC_STRIDE, computed modulo 2^N; exc_ack = 1<<sel_idx.
  - At the edge: ELR <= imem_addr; ERR <= next_pc; ESR <= zero-extended {sel_idx (4 bits), estatus[sel_idx]}; clear the pending bit; go to HANDLER.
- HANDLER:
  - in_handler=1; no new exception is taken; requests keep accumulating.
  - eret==1 sets pc_branch = ERR; at the next edge the state returns to IDLE.
  - If eligible != 0 on return, the next exception is taken with TAKE in the following cycle. No back-to-back in the same cycle.
- Outputs outside TAKE: eproc=0, exc_ack=0, evaddr=VEC_BASE.
- pc_branch is combinational: ERR when state==HANDLER and eret, else alu_branch.
- read_data is combinational: edata_sel 00 gives ERR, 01 gives ELR, 10 gives ESR, 11 gives 0.
- Latency: a request pulsed in cycle c is pending from c+1. With IDLE and enabled, eproc is high in cycle c+2.
- Reset values of outputs: exc_ack=0, eproc=0, evaddr=VEC_BASE, in_handler=0, read_data=0, pc_branch=alu_branch.

Test Plan:
- Reset low 2 cycles with exc_req=4'hF -> pending=0, eproc=0, read_data=0 for all edata_sel; after release with exc_req=0 the state stays IDLE.
- exc_req=4'b0100 pulsed in cycle c, exc_en=4'hF, imem_addr=0x100, next_pc=0x104, estatus[11:8]=4'h3 ->
  - cycle c+2: eproc=1, evaddr=0x118, exc_ack=4'b0100;
  - then ERR=0x104, ELR=0x100, ESR=0x23, in_handler=1.
- exc_req=4'b1010 in the same cycle -> source 1 taken first (evaddr=0xF8). After ERET, source 3 is taken (evaddr=0x138) one cycle after returning to IDLE.
- Request on source 0 while in HANDLER, then eret with alu_branch=0x500 and ERR=0x104 -> pc_branch=0x104 and no ack until back in IDLE; next cycle TAKE with evaddr=0xD8.
- exc_en=4'b1110 with request on source 0 -> stays pending with no eproc for 10 cycles; setting exc_en[0]=1 -> TAKE on the next cycle. eret pulsed in IDLE -> pc_branch=alu_branch and state unchanged.
- reset asserted during HANDLER -> next cycle IDLE, ELR/ERR/ESR=0, in_handler=0, pending cleared.
